// File: rtl/yrv_board_pkg.sv
// rtl/yrv_board_pkg.sv - port_in field layout and key input defaults
package yrv_board_pkg;

  localparam int PORT_W                  = 16;
  localparam int MAX_KEYS                = 4;
  localparam int LEVEL_LSB               = 0;
  localparam int PRESS_LSB               = 4;
  localparam int RELEASE_LSB             = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  // Key state widened to the full four-key layout; unused keys stay zero.
  typedef struct packed {
    logic [MAX_KEYS-1:0] release_f;
    logic [MAX_KEYS-1:0] press_f;
    logic [MAX_KEYS-1:0] level;
  } key_fields_t;

  // Place each field at its fixed offset; bits [15:12] are always zero.
  function automatic logic [PORT_W-1:0] pack_port(input key_fields_t f);
    logic [PORT_W-1:0] w;
    w = '0;
    w[LEVEL_LSB   +: MAX_KEYS] = f.level;
    w[PRESS_LSB   +: MAX_KEYS] = f.press_f;
    w[RELEASE_LSB +: MAX_KEYS] = f.release_f;
    return w;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, polarity fix and debounce for one key
module key_debounce
  import yrv_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic press_evt,
  output logic release_evt
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           IDLE_RAW = (ACTIVE_LOW != 0);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic          pressed;
  logic          differ;
  logic          accept;

  // Two-flop synchronizer; reset loads the idle pin value so no event follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {2{IDLE_RAW}};
    end else begin
      sync_q <= {sync_q[0], key_raw};
    end
  end

  assign pressed = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];
  assign differ  = (pressed != level);
  assign accept  = differ && (cnt == CNT_LAST);

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (!differ) begin
      cnt   <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= pressed;
      cnt   <= '0;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  // Edge strobes coincide with the level update so flags land on the same edge.
  always_comb begin
    press_evt   = accept &  pressed;
    release_evt = accept & ~pressed;
  end

endmodule

// File: rtl/key_input_port.sv
// rtl/key_input_port.sv - debounced key port with sticky flags and interrupt
module key_input_port
  import yrv_board_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic              clr_strobe,
  input  logic [N_KEYS-1:0] clr_mask,
  input  logic              irq_en,
  output logic [15:0]       port_in,
  output logic              irq
);

  logic [N_KEYS-1:0] level_vec;
  logic [N_KEYS-1:0] press_evt;
  logic [N_KEYS-1:0] release_evt;
  logic [N_KEYS-1:0] press_flag;
  logic [N_KEYS-1:0] release_flag;
  logic [N_KEYS-1:0] clr_vec;
  key_fields_t       fields;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
      .clk         (clk),
      .reset       (reset),
      .key_raw     (key_raw[g]),
      .level       (level_vec[g]),
      .press_evt   (press_evt[g]),
      .release_evt (release_evt[g])
    );
  end

  assign clr_vec = {N_KEYS{clr_strobe}} & clr_mask;

  // Sticky flags: a new event in the clearing cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_flag   <= '0;
      release_flag <= '0;
    end else begin
      press_flag   <= (press_flag   & ~clr_vec) | press_evt;
      release_flag <= (release_flag & ~clr_vec) | release_evt;
    end
  end

  // Widen the per-key vectors to the fixed four-key layout.
  always_comb begin
    fields = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      fields.level[i]     = level_vec[i];
      fields.press_f[i]   = press_flag[i];
      fields.release_f[i] = release_flag[i];
    end
  end

  // Register the MCU-visible word and the interrupt; releases never interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      port_in <= '0;
      irq     <= 1'b0;
    end else begin
      port_in <= pack_port(fields);
      irq     <= irq_en & (|press_flag);
    end
  end

endmodule

// File: tb/tb_key_input_port.sv
// tb/tb_key_input_port.sv - scoreboard bench for key_input_port
module tb_key_input_port;

  localparam int N = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_raw;
  logic        clr_strobe;
  logic [3:0]  clr_mask;
  logic        irq_en;
  logic [15:0] port_in;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [15:0] port;
    logic        irq;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  key_input_port #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_raw),
    .clr_strobe (clr_strobe),
    .clr_mask   (clr_mask),
    .irq_en     (irq_en),
    .port_in    (port_in),
    .irq        (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: a key level flips once the synchronized value has
  // disagreed with it for D consecutive clock edges (a sliding window).
  bit m_valid = 1'b0;
  bit s1[N], s2[N], lvl[N], pf[N], rf[N];
  bit hist[N][$];
  bit m_irq;
  logic [15:0] m_port;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        s1[k] = 0; s2[k] = 0; lvl[k] = 0; pf[k] = 0; rf[k] = 0;
        hist[k].delete();
      end
      m_port  = '0;
      m_irq   = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      bit anyp;
      anyp   = 0;
      m_port = '0;
      for (int k = 0; k < N; k++) begin
        m_port[k]     = lvl[k];
        m_port[4 + k] = pf[k];
        m_port[8 + k] = rf[k];
        anyp = anyp | pf[k];
      end
      m_irq = irq_en & anyp;
      for (int k = 0; k < N; k++) begin
        bit ev_p, ev_r, all_diff, clr;
        ev_p = 0; ev_r = 0;
        hist[k].push_back(s2[k]);
        if (hist[k].size() > D) void'(hist[k].pop_front());
        all_diff = (hist[k].size() == D);
        foreach (hist[k][j]) if (hist[k][j] == lvl[k]) all_diff = 0;
        if (all_diff) begin
          lvl[k] = !lvl[k];
          ev_p = lvl[k];
          ev_r = !lvl[k];
        end
        clr   = clr_strobe & clr_mask[k];
        pf[k] = (pf[k] & !clr) | ev_p;
        rf[k] = (rf[k] & !clr) | ev_r;
        s2[k] = s1[k];
        s1[k] = !key_raw[k];
      end
    end
    if (m_valid) exp_q.push_back('{m_port, m_irq});
  end

  // Monitor: compare the registered outputs against the model every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("sb_port_in", 32'(port_in), 32'(e.port));
      check("sb_irq", 32'(irq), 32'(e.irq));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int hold[N];

  initial begin
    reset = 1'b1; key_raw = 4'hF; clr_strobe = 1'b0; clr_mask = 4'h0; irq_en = 1'b1;
    cycles(3);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      check("idle_port", 32'(port_in), 32'h0);
      check("idle_irq", 32'(irq), 32'h0);
    end

    // Key 1 press: level and press flag visible 11 edges after the change.
    key_raw[1] = 1'b0;
    cycles(10);
    check("press_early", 32'(port_in), 32'h0);
    cycles(1);
    check("press_port", 32'(port_in), 32'h0022);
    cycles(1);
    check("press_irq", 32'(irq), 32'h1);

    // Short glitch on key 2 must leave everything untouched.
    key_raw[2] = 1'b0;
    cycles(5);
    key_raw[2] = 1'b1;
    cycles(20);
    check("glitch_port", 32'(port_in), 32'h0022);

    // Release key 1, then clear its flags.
    key_raw[1] = 1'b1;
    cycles(11);
    check("release_port", 32'(port_in), 32'h0220);
    check("release_irq", 32'(irq), 32'h1);
    clr_strobe = 1'b1; clr_mask = 4'h2;
    cycles(1);
    clr_strobe = 1'b0; clr_mask = 4'h0;
    cycles(1);
    check("clear_port", 32'(port_in), 32'h0);
    check("clear_irq", 32'(irq), 32'h0);

    // Clear of key 0 coinciding with its press: the set wins.
    key_raw[0] = 1'b0;
    cycles(9);
    clr_strobe = 1'b1; clr_mask = 4'h1;
    cycles(1);
    clr_strobe = 1'b0; clr_mask = 4'h0;
    cycles(1);
    check("setwin_port", 32'(port_in), 32'h0011);
    cycles(1);
    check("setwin_irq", 32'(irq), 32'h1);
    key_raw[0] = 1'b1;
    cycles(12);
    clr_strobe = 1'b1; clr_mask = 4'hF;
    cycles(1);
    clr_strobe = 1'b0; clr_mask = 4'h0;
    cycles(2);
    check("cleanup_port", 32'(port_in), 32'h0);

    // Reset in the middle of a key 3 debounce, key held through release.
    key_raw[3] = 1'b0;
    cycles(6);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      check("midreset_port", 32'(port_in), 32'h0);
    end
    reset = 1'b0;
    cycles(10);
    check("rehold_early", 32'(port_in), 32'h0);
    cycles(1);
    check("rehold_port", 32'(port_in), 32'h0088);
    key_raw[3] = 1'b1;
    cycles(12);

    // Randomized traffic, checked only by the scoreboard.
    for (int k = 0; k < N; k++) hold[k] = $urandom_range(14, 1);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        hold[k]--;
        if (hold[k] <= 0) begin
          key_raw[k] = ~key_raw[k];
          hold[k] = $urandom_range(14, 1);
        end
      end
      clr_strobe = ($urandom_range(7, 0) == 0);
      clr_mask   = 4'($urandom_range(15, 0));
      if ($urandom_range(49, 0) == 0) irq_en = ~irq_en;
      reset = ($urandom_range(399, 0) == 0);
    end
    reset = 1'b0; clr_strobe = 1'b0;
    cycles(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_input_port.md
KEY_INPUT_PORT -- requirements
Module: key_input_port

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of keys handled (legal range 1..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, stable cycles required to accept a key change (1 ms at 50 MHz; minimum 2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 means raw key pin low = pressed.
REQ-004 SHALL have port: clk  input  1  single clock for all logic.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: key_raw  input  N_KEYS  asynchronous board key pins.
REQ-007 SHALL have port: clr_strobe  input  1  one-cycle request to clear event flags.
REQ-008 SHALL have port: clr_mask  input  N_KEYS  keys whose flags clr_strobe clears.
REQ-009 SHALL have port: irq_en  input  1  enables the interrupt output.
REQ-010 SHALL have port: port_in  output  16  MCU input-port word.
REQ-011 SHALL have port: irq  output  1  registered interrupt request, level.

Function
REQ-012 SHALL pass each key_raw bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL normalize polarity after the synchronizer so that internal 1 = pressed.
REQ-014 SHALL keep per key a debounced level and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-015 Counter SHALL increment each cycle while the synchronized value differs from the level, and clear to 0 in any cycle where they are equal.
REQ-016 Level SHALL take the synchronized value, and the counter SHALL clear, in the cycle the counter equals DEBOUNCE_CYCLES-1 while the values still differ.
REQ-017 A raw change held steady SHALL appear on the level bit exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling the new raw value.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no level change and no flag.
REQ-019 A level 0->1 transition SHALL set that key's press flag; a 1->0 transition SHALL set its release flag; flags are sticky.
REQ-020 clr_strobe=1 SHALL clear the press and release flags of every key with clr_mask bit set, on the next edge.
REQ-021 When a set and a clear hit the same flag in one cycle, the set SHALL win.
REQ-022 port_in SHALL be registered: [3:0] levels, [7:4] press flags, [11:8] release flags, [15:12] zero; bits for keys at index >= N_KEYS read 0.
REQ-023 port_in SHALL reflect level and flag updates one cycle after they occur internally.
REQ-024 irq SHALL be registered as irq_en AND (OR of all press flags); it deasserts one cycle after the last press flag clears or irq_en drops.
REQ-025 Release flags SHALL NOT contribute to irq.

Reset
REQ-026 On reset=1 at a clock edge, levels, flags, counters, port_in and irq SHALL be 0.
REQ-027 On reset, synchronizer flops SHALL load the unpressed raw value (1 if ACTIVE_LOW, else 0) so that releasing reset with keys idle creates no event.
REQ-028 Reset asserted mid-debounce SHALL abandon the count; no flag is set by the pending change.
REQ-029 A key held pressed through reset release SHALL be accepted as a new press after DEBOUNCE_CYCLES+2 cycles.

Structure
REQ-030 Package yrv_board_pkg SHALL hold the port_in field offsets (LEVEL_LSB=0, PRESS_LSB=4, RELEASE_LSB=8) and the default debounce constant.
REQ-031 A sub-module key_debounce SHALL implement REQ-012..REQ-019 for one key, instantiated N_KEYS times via generate; flag clearing, port_in and irq logic stay in key_input_port.

Verification (DEBOUNCE_CYCLES=8, N_KEYS=4, ACTIVE_LOW=1)
REQ-032 Reset with key_raw=4'hF, run 20 cycles -> port_in=16'h0000, irq=0 throughout.
REQ-033 key_raw[1] 1->0, held steady -> port_in[1]=1 and port_in[5]=1 exactly 11 edges later (10 plus register stage); irq=1 one cycle after, with irq_en=1.
REQ-034 key_raw[2] low pulse of 5 cycles -> port_in stays 16'h0000, irq stays 0.
REQ-035 After REQ-033, release key 1 -> port_in=16'h0220; then clr_strobe with clr_mask=4'h2 -> port_in=16'h0000 and irq=0 within 2 cycles.
REQ-036 clr_strobe with clr_mask=4'h1 in the same cycle key 0's press flag is set -> flag remains 1, irq stays 1.
REQ-037 Reset asserted at cycle 4 of a key 3 press debounce, key_raw[3] held low -> port_in=0 during reset; press flag sets 10 edges after reset release.
